// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Purpose : APB requester. Converts a valid/ready command into one APB
//           SETUP/ACCESS transfer at a time and reports completion on a
//           single-cycle response strobe.
// Ports   : clk, reset (sync, active-high)
//           cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command in
//           rsp_valid/rsp_rdata/rsp_err                       response out
//           paddr/pwrite/psel/penable/pwdata                  APB out
//           prdata/pready                                     APB in
// Config  : `define APB_TIMEOUT_EN to abort transfers that wait
//           TIMEOUT_CYCLES ACCESS cycles without pready (rsp_err=1).
//           Undefined: the master waits forever and rsp_err stays 0.
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int unsigned addrWidth      = 5,
  parameter int unsigned dataWidth      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic                 psel,
  output logic                 penable,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_psel_nxt;
  logic                 w_penable_nxt;
  logic                 w_pwrite_nxt;
  logic [addrWidth-1:0] w_paddr_nxt;
  logic [dataWidth-1:0] w_pwdata_nxt;
  logic                 w_rsp_valid_nxt;
  logic                 w_rsp_err_nxt;
  logic [dataWidth-1:0] w_rsp_rdata_nxt;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
`else
  // Limit is meaningless without the timeout; a zero value is simply accepted.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Commands are only taken while idle and out of reset.
  assign cmd_ready = (r_state == IDLE) && !reset;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_psel_nxt      = psel;
    w_penable_nxt   = penable;
    w_pwrite_nxt    = pwrite;
    w_paddr_nxt     = paddr;
    w_pwdata_nxt    = pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = rsp_rdata;
`ifdef APB_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_state_nxt   = SETUP;
          w_paddr_nxt   = cmd_addr;
          w_pwrite_nxt  = cmd_write;
          // Reads drive zero so the bus never carries stale write data.
          w_pwdata_nxt  = cmd_write ? cmd_wdata : '0;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
        end
      end
      SETUP: begin
        w_state_nxt   = ACCESS;
        w_penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
        w_cnt_nxt     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          w_state_nxt     = IDLE;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          if (!pwrite) begin
            w_rsp_rdata_nxt = prdata;
          end
        end
`ifdef APB_TIMEOUT_EN
        // pready on the final allowed cycle still completes normally.
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt     = IDLE;
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      default: begin
        w_state_nxt   = IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      psel      <= w_psel_nxt;
      penable   <= w_penable_nxt;
      pwrite    <= w_pwrite_nxt;
      paddr     <= w_paddr_nxt;
      pwdata    <= w_pwdata_nxt;
      rsp_valid <= w_rsp_valid_nxt;
      rsp_err   <= w_rsp_err_nxt;
      rsp_rdata <= w_rsp_rdata_nxt;
`ifdef APB_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Purpose : self-checking bench for apb_master. A behavioural APB slave memory
//           and the last-read-data register form the reference model; each
//           scenario task drives stimulus and compares cycle by cycle.
// -----------------------------------------------------------------------------
module tb_apb_master;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;

  int checks = 0;
  int errors = 0;

  // Reference model: slave memory and the expected held read data.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] exp_rdata;

  apb_master #(.addrWidth(AW), .dataWidth(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transfer with nwait wait states; DUT must be idle on entry.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int nwait);
    logic [DW-1:0] exp_pw;
    logic [17:0]   obs;
    logic [17:0]   exp;
    exp_pw = wr ? d : '0;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL xfer_ready_idle got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    pready = 1'($urandom); prdata = DW'($urandom);
    step();
    // Command inputs are don't-care outside IDLE.
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
    cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    obs = {psel, penable, cmd_ready, rsp_valid, paddr, pwrite, pwdata};
    exp = {1'b1, 1'b0, 1'b0, 1'b0, a, wr, exp_pw};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL setup_phase got=%h want=%h", obs, exp);
    end
    step();
    for (int w = 0; w <= nwait; w++) begin
      obs = {psel, penable, cmd_ready, rsp_valid, paddr, pwrite, pwdata};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, a, wr, exp_pw};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL access_phase w=%0d got=%h want=%h", w, obs, exp);
      end
      pready = (w == nwait);
      prdata = (w == nwait && !wr) ? mem[a] : DW'($urandom);
      step();
    end
    cmd_valid = 1'b0;
    pready = 1'($urandom); prdata = DW'($urandom);
    if (wr) mem[a] = d;
    else    exp_rdata = mem[a];
    obs = {psel, penable, cmd_ready, rsp_valid, rsp_err, paddr, rsp_rdata};
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a, exp_rdata};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL complete got=%h want=%h", obs, exp);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_pulse_width got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '1; cmd_wdata = '1;
    pready = 1'b1; prdata = '0;
    step();
    step();
    exp_rdata = '0;
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata, cmd_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values psel=%b pen=%b pw=%b rv=%b re=%b pa=%h pwd=%h rd=%h rdy=%b",
               psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata, cmd_ready);
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want=1", cmd_ready);
    end
    step();
  endtask

  task automatic test_write_read();
    xfer(1'b1, 5'h03, 8'hA5, 0);
    xfer(1'b0, 5'h03, 8'h00, 0);
    checks++;
    if (rsp_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL readback_a5 got=%h want=a5", rsp_rdata);
    end
  endtask

  task automatic test_wait_read();
    xfer(1'b1, 5'h07, 8'h5A, 0);
    xfer(1'b0, 5'h07, 8'h00, 3);
    xfer(1'b1, 5'h07, 8'h11, 2);
    checks++;
    if (rsp_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL write_keeps_rdata got=%h want=5a", rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd1; cmd_wdata = 8'h21; pready = 1'b1;
    step();
    checks++;
    if ({psel, penable, paddr} !== {1'b1, 1'b0, 5'd1}) begin
      errors++;
      $display("FAIL b2b_setup1 psel=%b pen=%b paddr=%h", psel, penable, paddr);
    end
    cmd_addr = 5'd2; cmd_wdata = 8'h42;
    step();
    checks++;
    if ({cmd_ready, penable} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_access1 rdy=%b pen=%b want rdy=0 pen=1", cmd_ready, penable);
    end
    step();
    mem[1] = 8'h21;
    checks++;
    if ({rsp_valid, cmd_ready, psel} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_done1 rv=%b rdy=%b psel=%b want 110", rsp_valid, cmd_ready, psel);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({psel, penable, paddr, pwdata} !== {1'b1, 1'b0, 5'd2, 8'h42}) begin
      errors++;
      $display("FAIL b2b_setup2 psel=%b pen=%b paddr=%h pwdata=%h", psel, penable, paddr, pwdata);
    end
    step();
    step();
    mem[2] = 8'h42;
    checks++;
    if ({rsp_valid, rsp_err, psel, penable} !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_done2 rv=%b re=%b psel=%b pen=%b", rsp_valid, rsp_err, psel, penable);
    end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) begin
        pready = 1'($urandom); prdata = DW'($urandom);
        step();
        checks++;
        if ({psel, rsp_valid, cmd_ready} !== 3'b001) begin
          errors++;
          $display("FAIL idle_quiet psel=%b rv=%b rdy=%b", psel, rsp_valid, cmd_ready);
        end
      end
      xfer(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h0C; pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    exp_rdata = '0;
    checks++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid psel=%b pen=%b rv=%b rdy=%b", psel, penable, rsp_valid, cmd_ready);
    end
    reset = 1'b0; pready = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready got=%b want=1", cmd_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({rsp_valid, psel, rsp_rdata} !== {2'b00, exp_rdata}) begin
        errors++;
        $display("FAIL reset_mid_dropped rv=%b psel=%b rd=%h", rsp_valid, psel, rsp_rdata);
      end
    end
  endtask

  task automatic test_timeout();
    int cnt;
    logic ok;
    xfer(1'b0, 5'h03, 8'h00, 0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h09; pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
`ifdef APB_TIMEOUT_EN
    cnt = 0;
    while (psel && penable && cnt < 100) begin
      cnt++;
      prdata = DW'($urandom);
      step();
    end
    checks++;
    if (cnt != int'(TO)) begin
      errors++;
      $display("FAIL timeout_len got=%0d want=%0d", cnt, TO);
    end
    checks++;
    if ({rsp_valid, rsp_err, psel, penable, rsp_rdata} !== {4'b1100, exp_rdata}) begin
      errors++;
      $display("FAIL timeout_rsp rv=%b re=%b psel=%b pen=%b rd=%h want rd=%h",
               rsp_valid, rsp_err, psel, penable, rsp_rdata, exp_rdata);
    end
    step();
    xfer(1'b0, 5'h0A, 8'h00, int'(TO) - 1);
`else
    ok = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (!(psel && penable) || rsp_valid || rsp_err) ok = 1'b0;
      cnt++;
      prdata = DW'($urandom);
      step();
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout_hold cycles=%0d psel=%b pen=%b rv=%b re=%b",
               cnt, psel, penable, rsp_valid, rsp_err);
    end
    pready = 1'b1; prdata = mem[9];
    step();
    pready = 1'b0;
    exp_rdata = mem[9];
    checks++;
    if ({rsp_valid, rsp_err, psel, rsp_rdata} !== {3'b100, exp_rdata}) begin
      errors++;
      $display("FAIL late_complete rv=%b re=%b psel=%b rd=%h want rd=%h",
               rsp_valid, rsp_err, psel, rsp_rdata, exp_rdata);
    end
    step();
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
    exp_rdata = '0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0;
    test_reset();
    test_write_read();
    test_wait_read();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
